// File: rtl/acia_tx_if.sv
// acia_tx_if: CPU write port, baud enable, line-control config and serial
// line of the ACIA transmitter, bundled so checkers can bind to one place.
//
// Handshake: TXLOAD is a one-cycle write strobe with no ready. The CPU
// should poll TXEMPTY=1 before writing. A write while TXEMPTY=0 silently
// replaces the pending byte. TXEMPTY returns to 1 on the cycle after the
// byte moves into the shift register.
interface acia_tx_if;
    logic       BAUD_TICK;
    logic [7:0] TXDATA;
    logic       TXLOAD;
    logic       TXEMPTY;
    logic       TXBUSY;
    logic       TX;
    logic       CTSB;
    logic [1:0] R_PMC;
    logic       R_PME;
    logic       R_SBN;

    modport master (
        output BAUD_TICK, TXDATA, TXLOAD, CTSB, R_PMC, R_PME, R_SBN,
        input  TXEMPTY, TXBUSY, TX
    );

    modport slave (
        input  BAUD_TICK, TXDATA, TXLOAD, CTSB, R_PMC, R_PME, R_SBN,
        output TXEMPTY, TXBUSY, TX
    );
endinterface

// File: rtl/acia_tx.sv
// acia_tx: 6551-style transmitter. It has a holding register (TDR) and a
// shift register, and it sends start, 8 data bits LSB first, optional
// parity, then 1 or 2 stop bits. Each bit lasts OVERSAMPLE BAUD_TICK pulses.
// Optional build macro: ACIA_TX_CTS_EN. When it is defined, transfers wait
// for CTSB=0.
module acia_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic        PHI2,
    input  logic        RESET,
    acia_tx_if.slave    bus,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic [2:0] state, state_nxt;
    logic [3:0] div;
    logic [2:0] bitcnt;
    logic [7:0] tdr, shift;
    logic       txempty, txbusy;
    logic       pme_l, sbn_l, par_l;
    logic       cts_ok, can_xfer, bit_end, xfer, par_now;

`ifdef ACIA_TX_CTS_EN
    assign cts_ok = ~bus.CTSB;
`else
    logic unused_ctsb;
    assign unused_ctsb = bus.CTSB;
    assign cts_ok      = 1'b1;
`endif

    assign can_xfer  = ~txempty & cts_ok;
    assign bit_end   = bus.BAUD_TICK && (div == 4'(OVERSAMPLE - 1));
    assign state_dbg = state;

    // The parity value is computed from the byte as it leaves the TDR.
    always_comb begin
        case (bus.R_PMC)
            2'b00:   par_now = ~^tdr;
            2'b01:   par_now = ^tdr;
            2'b10:   par_now = 1'b1;
            default: par_now = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge PHI2) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic. xfer marks the edge where TDR moves into the shifter.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        case (state)
            S_IDLE: begin
                if (can_xfer) begin
                    state_nxt = S_START;
                    xfer      = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bitcnt == 3'd7) state_nxt = pme_l ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_nxt = S_STOP;
            end
            S_STOP, S_STOP2: begin
                if (bit_end) begin
                    if (state == S_STOP && sbn_l) begin
                        state_nxt = S_STOP2;
                    end else if (can_xfer) begin
                        state_nxt = S_START;
                        xfer      = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: the line level follows the current bit of the frame. It is mark while idle.
    always_comb begin
        bus.TX = 1'b1;
        case (state)
            S_START:  bus.TX = 1'b0;
            S_DATA:   bus.TX = shift[0];
            S_PARITY: bus.TX = par_l;
            default:  bus.TX = 1'b1;
        endcase
    end

    assign bus.TXEMPTY = txempty;
    assign bus.TXBUSY  = txbusy;

    // Datapath: TDR load, the transfer into the shifter, the per-frame config latch and the bit timing.
    always_ff @(posedge PHI2) begin
        if (RESET) begin
            tdr     <= 8'h00;
            shift   <= 8'h00;
            txempty <= 1'b1;
            txbusy  <= 1'b0;
            div     <= 4'd0;
            bitcnt  <= 3'd0;
            pme_l   <= 1'b0;
            sbn_l   <= 1'b0;
            par_l   <= 1'b0;
        end else begin
            // A write on the transfer edge wins: the old byte goes out and the new one waits.
            if (bus.TXLOAD) begin
                tdr     <= bus.TXDATA;
                txempty <= 1'b0;
            end else if (xfer) begin
                txempty <= 1'b1;
            end
            txbusy <= (state_nxt != S_IDLE);
            if (xfer) begin
                shift  <= tdr;
                div    <= 4'd0;
                bitcnt <= 3'd0;
                pme_l  <= bus.R_PME;
                sbn_l  <= bus.R_SBN & ~bus.R_PME;
                par_l  <= par_now;
            end else if (state != S_IDLE && bus.BAUD_TICK) begin
                div <= bit_end ? 4'd0 : div + 4'd1;
                if (bit_end && state == S_DATA) begin
                    shift  <= shift >> 1;
                    bitcnt <= bitcnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acia_tx.sv
// tb_acia_tx: self-checking bench for acia_tx. The frame model builds each
// frame as a list of line levels and plays it back one bit per OVERSAMPLE
// ticks. Directed tests pin the model to hand-computed frames, and the
// random phase covers the rest.
`timescale 1ns/1ps
module tb_acia_tx;

    localparam int OS = 16;

    logic       PHI2 = 1'b0;
    logic       RESET;
    logic [2:0] state_dbg;

    acia_tx_if bus ();

    acia_tx #(.OVERSAMPLE(OS)) dut (
        .PHI2      (PHI2),
        .RESET     (RESET),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 PHI2 = ~PHI2;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [0:0] exp_q[$];     // remaining line levels of the frame on the wire, one per bit
    logic [7:0] m_tdr  = 8'h00;
    logic       m_full = 1'b0;
    int         m_ticks = 0;

    function automatic logic cts_allows();
`ifdef ACIA_TX_CTS_EN
        return (bus.CTSB == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void build_frame(input logic [7:0] d, input logic [1:0] pmc,
                                        input logic pme, input logic sbn);
        int ones;
        logic par;
        ones = $countones(d);
        case (pmc)
            2'b00:   par = (ones % 2 == 0);
            2'b01:   par = (ones % 2 == 1);
            2'b10:   par = 1'b1;
            default: par = 1'b0;
        endcase
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pme) exp_q.push_back(par);
        exp_q.push_back(1'b1);
        if (sbn && !pme) exp_q.push_back(1'b1);
    endfunction

    // Model update at each active edge, using the inputs the DUT samples.
    always @(posedge PHI2) begin
        if (RESET) begin
            exp_q.delete();
            m_full  = 1'b0;
            m_tdr   = 8'h00;
            m_ticks = 0;
        end else begin
            if (exp_q.size() != 0 && bus.BAUD_TICK) begin
                m_ticks++;
                if (m_ticks == OS) begin
                    m_ticks = 0;
                    exp_q.delete(0);
                end
            end
            if (m_full && cts_allows() && exp_q.size() == 0) begin
                build_frame(m_tdr, bus.R_PMC, bus.R_PME, bus.R_SBN);
                m_ticks = 0;
                m_full  = 1'b0;
            end
            if (bus.TXLOAD) begin
                m_tdr  = bus.TXDATA;
                m_full = 1'b1;
            end
        end
    end

    // Compare DUT against the model on the opposite edge.
    always @(negedge PHI2) begin
        if (chk_en) begin
            check("tx", 32'(bus.TX), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd1);
            check("txbusy", 32'(bus.TXBUSY), 32'(exp_q.size() != 0));
            check("txempty", 32'(bus.TXEMPTY), 32'(!m_full));
            check("state_legal", 32'(state_dbg <= 3'd5), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    logic [0:0] cap_q[$];

    task automatic step();
        @(posedge PHI2);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        bus.TXDATA = d;
        bus.TXLOAD = 1'b1;
        step();
        bus.TXLOAD = 1'b0;
    endtask

    // Records TX on every busy cycle of the next busy stretch.
    task automatic capture(output int waits, output logic first_empty);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        waits = 0;
        first_empty = 1'b0;
        cap_q.delete();
        while (n < 3000) begin
            @(negedge PHI2);
            n++;
            if (bus.TXBUSY) begin
                if (!seen) first_empty = bus.TXEMPTY;
                seen = 1;
                cap_q.push_back(bus.TX);
            end else if (seen) begin
                break;
            end else begin
                waits++;
            end
        end
        check("capture_bounded", 32'(n < 3000), 32'd1);
    endtask

    function automatic logic cap_bit(input int i);
        int idx;
        idx = i * OS + OS / 2;
        if (idx < cap_q.size()) return cap_q[idx];
        return 1'bx;
    endfunction

    function automatic logic [7:0] cap_byte(input int start_bit);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = cap_bit(start_bit + 1 + b);
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int cnt;
        logic fe;
        logic [9:0] pat_55;

        bus.BAUD_TICK = 1'b1;
        bus.TXDATA    = 8'h00;
        bus.TXLOAD    = 1'b0;
        bus.CTSB      = 1'b0;
        bus.R_PMC     = 2'b00;
        bus.R_PME     = 1'b0;
        bus.R_SBN     = 1'b0;
        RESET         = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_tx", 32'(bus.TX), 32'd1);
        check("rst_txempty", 32'(bus.TXEMPTY), 32'd1);
        check("rst_txbusy", 32'(bus.TXBUSY), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        RESET = 1'b0;
        step();

        // 8N1 0x55
        pat_55 = 10'b10_1010_1010;
        load(8'h55);
        check("8n1_empty_after_load", 32'(bus.TXEMPTY), 32'd0);
        capture(w, fe);
        check("8n1_len", cap_q.size(), 32'd160);
        check("8n1_wait", w, 32'd1);
        check("8n1_empty_at_xfer", 32'(fe), 32'd1);
        for (int i = 0; i < 10; i++) check("8n1_bit", 32'(cap_bit(i)), 32'(pat_55[i]));

        // Odd then even parity, R_SBN ignored
        bus.R_PME = 1'b1;
        bus.R_SBN = 1'b1;
        bus.R_PMC = 2'b00;
        load(8'h07);
        capture(w, fe);
        check("odd_len", cap_q.size(), 32'd176);
        check("odd_byte", 32'(cap_byte(0)), 32'h07);
        check("odd_par", 32'(cap_bit(9)), 32'd0);
        check("odd_stop", 32'(cap_bit(10)), 32'd1);
        bus.R_PMC = 2'b01;
        load(8'h07);
        capture(w, fe);
        check("even_len", cap_q.size(), 32'd176);
        check("even_par", 32'(cap_bit(9)), 32'd1);

        // 8N2
        bus.R_PME = 1'b0;
        load(8'hA3);
        capture(w, fe);
        check("8n2_len", cap_q.size(), 32'd176);
        check("8n2_byte", 32'(cap_byte(0)), 32'hA3);
        check("8n2_stop1", 32'(cap_bit(9)), 32'd1);
        check("8n2_stop2", 32'(cap_bit(10)), 32'd1);
        bus.R_SBN = 1'b0;

        // Back-to-back with no idle gap
        load(8'h41);
        fork
            capture(w, fe);
            begin
                repeat (40) step();
                load(8'h42);
            end
        join
        check("b2b_len", cap_q.size(), 32'd320);
        check("b2b_first", 32'(cap_byte(0)), 32'h41);
        check("b2b_start2", 32'(cap_bit(10)), 32'd0);
        check("b2b_second", 32'(cap_byte(10)), 32'h42);

        // Overwrite while busy
        load(8'h33);
        fork
            capture(w, fe);
            begin
                repeat (30) step();
                load(8'h11);
                repeat (10) step();
                load(8'h22);
            end
        join
        check("ovw_len", cap_q.size(), 32'd320);
        check("ovw_first", 32'(cap_byte(0)), 32'h33);
        check("ovw_second", 32'(cap_byte(10)), 32'h22);

        // Load on the transfer edge
        load(8'h61);
        load(8'h62);
        check("simul_empty", 32'(bus.TXEMPTY), 32'd0);
        check("simul_busy", 32'(bus.TXBUSY), 32'd1);
        capture(w, fe);
        check("simul_len", cap_q.size(), 32'd320);
        check("simul_first", 32'(cap_byte(0)), 32'h61);
        check("simul_second", 32'(cap_byte(10)), 32'h62);

        // Reset during data bit 4
        load(8'hF0);
        repeat (88) step();
        check("rstmid_in_data", 32'(state_dbg), 32'd2);
        check("rstmid_bit4", 32'(bus.TX), 32'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rstmid_tx", 32'(bus.TX), 32'd1);
        check("rstmid_busy", 32'(bus.TXBUSY), 32'd0);
        check("rstmid_empty", 32'(bus.TXEMPTY), 32'd1);
        cnt = 0;
        repeat (200) begin
            step();
            if (bus.TXBUSY !== 1'b0) cnt++;
        end
        check("rstmid_no_residual", cnt, 32'd0);

`ifdef ACIA_TX_CTS_EN
        // CTS gating
        bus.CTSB = 1'b1;
        load(8'h5A);
        cnt = 0;
        repeat (100) begin
            step();
            if (bus.TX !== 1'b1 || bus.TXEMPTY !== 1'b0) cnt++;
        end
        check("cts_hold", cnt, 32'd0);
        bus.CTSB = 1'b0;
        fork
            capture(w, fe);
            begin
                repeat (50) step();
                bus.CTSB = 1'b1;
            end
        join
        check("cts_wait", w, 32'd1);
        check("cts_len", cap_q.size(), 32'd160);
        check("cts_byte", 32'(cap_byte(0)), 32'h5A);
        bus.CTSB = 1'b0;
`endif

        // Random phase against the model
        for (int c = 0; c < 15000; c++) begin
            bus.BAUD_TICK = ($urandom_range(0, 2) != 0);
            bus.TXLOAD    = ($urandom_range(0, 39) == 0);
            bus.TXDATA    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 59) == 0)
                {bus.R_PMC, bus.R_PME, bus.R_SBN} = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) bus.CTSB = ~bus.CTSB;
            RESET = ($urandom_range(0, 2999) == 0);
            step();
        end
        bus.TXLOAD    = 1'b0;
        bus.BAUD_TICK = 1'b1;
        bus.CTSB      = 1'b0;
        RESET         = 1'b0;
        repeat (400) step();
        check("drain_idle", 32'(bus.TXBUSY), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
